// File: rtl/neuron_b_backprop_pkg.sv
// Shared constants and FSM encoding for the backward-pass neuron.
// Values are signed Q8.24 words.
package neuron_b_backprop_pkg;
  localparam int WIDTH = 32;
  localparam int FBITS = 24;
  localparam int N_IN  = 9;
  localparam int IDX_W = 4;

  localparam logic [WIDTH-1:0] ONE = 32'd1 << FBITS;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ,
    S_DER,
    S_LRD,
    S_PROP,
    S_UPD,
    S_DONE
  } state_t;
endpackage

// File: rtl/neuron_b_backprop_mult_q.sv
// Fixed-point signed multiply: full product, arithmetic shift by FBITS,
// keep the low WIDTH bits (floor rounding, two's-complement wrap).
module neuron_b_backprop_mult_q #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] prod
);
  logic signed [2*WIDTH-1:0] prod_full;
  logic                      unused_bits;

  assign prod_full   = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) *
                       $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
  // Taking bits [FBITS +: WIDTH] equals (prod_full >>> FBITS) truncated.
  assign prod        = prod_full[FBITS +: WIDTH];
  assign unused_bits = ^{prod_full[FBITS-1:0], prod_full[2*WIDTH-1:FBITS+WIDTH]};
endmodule

// File: rtl/neuron_b_backprop.sv
// Backward pass of a 9-input tanh neuron, time-multiplexed over one
// Q8.24 multiplier: delta, bias/weight updates and propagated errors.
module neuron_b_backprop
  import neuron_b_backprop_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] err,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] lr,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8, a_9,
  input  logic [WIDTH-1:0] w_1, w_2, w_3, w_4, w_5, w_6, w_7, w_8, w_9,
  output logic [WIDTH-1:0] w_new_1, w_new_2, w_new_3, w_new_4, w_new_5,
  output logic [WIDTH-1:0] w_new_6, w_new_7, w_new_8, w_new_9,
  output logic [WIDTH-1:0] b_new,
  output logic [WIDTH-1:0] e_1, e_2, e_3, e_4, e_5, e_6, e_7, e_8, e_9,
  output logic [WIDTH-1:0] delta,
  output logic             busy,
  output logic             done
);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  word_t            err_q, err_d, y_q, y_d, lr_q, lr_d, b_q, b_d;
  word_t            t_q, t_d, ld_q, ld_d, delta_q, delta_d, b_new_q, b_new_d;
  word_t            e_q [N_IN];
  word_t            e_d [N_IN];
  word_t            w_new_q [N_IN];
  word_t            w_new_d [N_IN];
  word_t            a_arr [N_IN];
  word_t            w_arr [N_IN];
  word_t            op_a, op_b, prod;
  logic             accept;

  assign a_arr = '{a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8, a_9};
  assign w_arr = '{w_1, w_2, w_3, w_4, w_5, w_6, w_7, w_8, w_9};

  // A held start re-accepts on the edge that leaves DONE, so back-to-back
  // operations skip the IDLE cycle.
  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    state_q <= S_IDLE;
    else if (en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SQ;
      S_SQ:    state_d = S_DER;
      S_DER:   state_d = S_LRD;
      S_LRD:   state_d = S_PROP;
      S_PROP:  state_d = S_UPD;
      S_UPD:   state_d = (idx_q == IDX_W'(N_IN - 1)) ? S_DONE : S_PROP;
      S_DONE:  state_d = start ? S_SQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      S_SQ:   begin op_a = y_q;     op_b = y_q;          end
      S_DER:  begin op_a = err_q;   op_b = ONE - t_q;    end
      S_LRD:  begin op_a = lr_q;    op_b = delta_q;      end
      S_PROP: begin op_a = delta_q; op_b = w_arr[idx_q]; end
      S_UPD:  begin op_a = ld_q;    op_b = a_arr[idx_q]; end
      default: ;
    endcase
  end

  neuron_b_backprop_mult_q #(.WIDTH(WIDTH), .FBITS(FBITS)) u_mult_q (
    .op_a (op_a),
    .op_b (op_b),
    .prod (prod)
  );

  always_comb begin
    idx_d   = idx_q;
    err_d   = err_q;
    y_d     = y_q;
    lr_d    = lr_q;
    b_d     = b_q;
    t_d     = t_q;
    ld_d    = ld_q;
    delta_d = delta_q;
    b_new_d = b_new_q;
    if (accept) begin
      err_d = err;
      y_d   = y;
      lr_d  = lr;
      b_d   = b;
    end
    case (state_q)
      S_SQ:  t_d = prod;
      S_DER: delta_d = prod;
      S_LRD: begin
        ld_d    = prod;
        b_new_d = b_q - prod;
        idx_d   = '0;
      end
      S_UPD: idx_d = idx_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      err_q   <= '0;
      y_q     <= '0;
      lr_q    <= '0;
      b_q     <= '0;
      t_q     <= '0;
      ld_q    <= '0;
      delta_q <= '0;
      b_new_q <= '0;
    end else if (en) begin
      idx_q   <= idx_d;
      err_q   <= err_d;
      y_q     <= y_d;
      lr_q    <= lr_d;
      b_q     <= b_d;
      t_q     <= t_d;
      ld_q    <= ld_d;
      delta_q <= delta_d;
      b_new_q <= b_new_d;
    end
  end

  // Per-input result lanes; the index counter picks which lane loads.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
      always_comb begin
        e_d[gi]     = e_q[gi];
        w_new_d[gi] = w_new_q[gi];
        if (idx_q == IDX_W'(gi)) begin
          if (state_q == S_PROP) e_d[gi]     = prod;
          if (state_q == S_UPD)  w_new_d[gi] = w_arr[gi] - prod;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          e_q[gi]     <= '0;
          w_new_q[gi] <= '0;
        end else if (en) begin
          e_q[gi]     <= e_d[gi];
          w_new_q[gi] <= w_new_d[gi];
        end
      end
    end
  endgenerate

  assign delta   = delta_q;
  assign b_new   = b_new_q;
  assign e_1 = e_q[0]; assign e_2 = e_q[1]; assign e_3 = e_q[2];
  assign e_4 = e_q[3]; assign e_5 = e_q[4]; assign e_6 = e_q[5];
  assign e_7 = e_q[6]; assign e_8 = e_q[7]; assign e_9 = e_q[8];
  assign w_new_1 = w_new_q[0]; assign w_new_2 = w_new_q[1]; assign w_new_3 = w_new_q[2];
  assign w_new_4 = w_new_q[3]; assign w_new_5 = w_new_q[4]; assign w_new_6 = w_new_q[5];
  assign w_new_7 = w_new_q[6]; assign w_new_8 = w_new_q[7]; assign w_new_9 = w_new_q[8];
endmodule

// File: tb/tb_neuron_b_backprop.sv
// Directed self-checking bench for neuron_b_backprop: hand-computed
// Q8.24 results, latency, stall, back-to-back and mid-operation reset.
module tb_neuron_b_backprop;
  localparam logic [31:0] ONE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst, en, start;
  logic [31:0] err, y, lr, b;
  logic [31:0] a_in [9];
  logic [31:0] w_in [9];
  wire  [31:0] w_new_o [9];
  wire  [31:0] e_o [9];
  wire  [31:0] b_new, delta;
  wire         busy, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  neuron_b_backprop dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .err(err), .y(y), .lr(lr), .b(b),
    .a_1(a_in[0]), .a_2(a_in[1]), .a_3(a_in[2]), .a_4(a_in[3]), .a_5(a_in[4]),
    .a_6(a_in[5]), .a_7(a_in[6]), .a_8(a_in[7]), .a_9(a_in[8]),
    .w_1(w_in[0]), .w_2(w_in[1]), .w_3(w_in[2]), .w_4(w_in[3]), .w_5(w_in[4]),
    .w_6(w_in[5]), .w_7(w_in[6]), .w_8(w_in[7]), .w_9(w_in[8]),
    .w_new_1(w_new_o[0]), .w_new_2(w_new_o[1]), .w_new_3(w_new_o[2]),
    .w_new_4(w_new_o[3]), .w_new_5(w_new_o[4]), .w_new_6(w_new_o[5]),
    .w_new_7(w_new_o[6]), .w_new_8(w_new_o[7]), .w_new_9(w_new_o[8]),
    .b_new(b_new),
    .e_1(e_o[0]), .e_2(e_o[1]), .e_3(e_o[2]), .e_4(e_o[3]), .e_5(e_o[4]),
    .e_6(e_o[5]), .e_7(e_o[6]), .e_8(e_o[7]), .e_9(e_o[8]),
    .delta(delta), .busy(busy), .done(done)
  );

  // w_step != 0 gives lane-distinct weights w_i = i * w_step.
  task automatic set_vec(input logic [31:0] e_v, y_v, lr_v, b_v, a_v, w_v, w_step);
    err = e_v; y = y_v; lr = lr_v; b = b_v;
    for (int i = 0; i < 9; i++) begin
      a_in[i] = a_v;
      w_in[i] = (w_step != 0) ? w_step * (i + 1) : w_v;
    end
  endtask

  // Starts one operation; cyc = enabled-or-stalled edges from accept to done.
  task automatic run_op(input int stall_at, output int cyc);
    cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (stall_at != 0 && k == stall_at)     en = 1'b0;
      if (stall_at != 0 && k == stall_at + 5) en = 1'b1;
      if (done) begin cyc = k; break; end
    end
    $display("op: err=%h y=%h lr=%h b=%h -> done after %0d cycles", err, y, lr, b, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; start = 1'b0;
    set_vec(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: busy=%b done=%b required 0/0", busy, done); end
    n_cmp++; if (delta !== 32'h0 || b_new !== 32'h0) begin
      n_err++; $display("FAIL reset_data: delta=%h b_new=%h required 0/0", delta, b_new); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (e_o[i] !== 32'h0 || w_new_o[i] !== 32'h0) begin
        n_err++; $display("FAIL reset_lane%0d: e=%h w_new=%h required 0/0", i + 1, e_o[i], w_new_o[i]); end
    end
    rst = 1'b1;
    $display("reset: outputs cleared, released");
  endtask

  task automatic test_basic();
    int cyc;
    set_vec(ONE, 32'h0, 32'h0080_0000, 32'h0, ONE, 32'h0040_0000, 32'h0);
    run_op(0, cyc);
    n_cmp++; if (cyc !== 21) begin
      n_err++; $display("FAIL basic_latency: got %0d required 21", cyc); end
    n_cmp++; if (delta !== ONE || b_new !== 32'hFF80_0000) begin
      n_err++; $display("FAIL basic_delta_b: delta=%h b_new=%h required 01000000/ff800000", delta, b_new); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (e_o[i] !== 32'h0040_0000 || w_new_o[i] !== 32'hFFC0_0000) begin
        n_err++; $display("FAIL basic_lane%0d: e=%h w_new=%h required 00400000/ffc00000", i + 1, e_o[i], w_new_o[i]); end
    end
  endtask

  task automatic test_derivative();
    int cyc;
    set_vec(ONE, 32'h0080_0000, ONE, 32'h0, 32'h0, 32'h0, 32'h0010_0000);
    run_op(0, cyc);
    n_cmp++; if (delta !== 32'h00C0_0000 || b_new !== 32'hFF40_0000) begin
      n_err++; $display("FAIL deriv_delta_b: delta=%h b_new=%h required 00c00000/ff400000", delta, b_new); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (e_o[i] !== 32'h000C_0000 * (i + 1) || w_new_o[i] !== 32'h0010_0000 * (i + 1)) begin
        n_err++; $display("FAIL deriv_lane%0d: e=%h w_new=%h required %h/%h", i + 1, e_o[i], w_new_o[i],
                          32'h000C_0000 * (i + 1), 32'h0010_0000 * (i + 1)); end
    end
  endtask

  task automatic test_saturated();
    int cyc;
    set_vec(32'h1234_5678, ONE, 32'h0080_0000, 32'h0020_0000, ONE, 32'h0, 32'h0010_0000);
    run_op(0, cyc);
    n_cmp++; if (delta !== 32'h0 || b_new !== 32'h0020_0000) begin
      n_err++; $display("FAIL sat_delta_b: delta=%h b_new=%h required 0/00200000", delta, b_new); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (e_o[i] !== 32'h0 || w_new_o[i] !== 32'h0010_0000 * (i + 1)) begin
        n_err++; $display("FAIL sat_lane%0d: e=%h w_new=%h required 0/%h", i + 1, e_o[i], w_new_o[i],
                          32'h0010_0000 * (i + 1)); end
    end
  endtask

  // PROP(4) is entered on edge 9 after accept; edges 10..14 are stalled.
  task automatic test_stall();
    int cyc;
    set_vec(ONE, 32'h0, 32'h0080_0000, 32'h0, ONE, 32'h0040_0000, 32'h0);
    run_op(9, cyc);
    n_cmp++; if (cyc !== 26) begin
      n_err++; $display("FAIL stall_latency: got %0d required 26", cyc); end
    n_cmp++; if (delta !== ONE || b_new !== 32'hFF80_0000) begin
      n_err++; $display("FAIL stall_delta_b: delta=%h b_new=%h required 01000000/ff800000", delta, b_new); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (e_o[i] !== 32'h0040_0000 || w_new_o[i] !== 32'hFFC0_0000) begin
        n_err++; $display("FAIL stall_lane%0d: e=%h w_new=%h required 00400000/ffc00000", i + 1, e_o[i], w_new_o[i]); end
    end
  endtask

  // err=3 LSB then err=-3 LSB: exercises floor rounding of the products.
  task automatic test_back_to_back();
    int pulses = 0;
    int first_k = -1;
    int second_k = -1;
    logic prev_done = 1'b0;
    set_vec(32'h0000_0003, 32'h0, 32'h0080_0000, 32'h0, ONE, 32'h0040_0000, 32'h0);
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0) err = 32'hFFFF_FFFD;
      if (done && !prev_done) begin
        pulses++;
        $display("b2b: done pulse %0d at edge %0d delta=%h", pulses, k, delta);
        if (pulses == 1) begin
          first_k = k;
          n_cmp++; if (delta !== 32'h3 || b_new !== 32'hFFFF_FFFF || e_o[0] !== 32'h0 || w_new_o[8] !== 32'h003F_FFFF) begin
            n_err++; $display("FAIL b2b_op1: delta=%h b_new=%h e1=%h w_new9=%h required 3/ffffffff/0/003fffff",
                              delta, b_new, e_o[0], w_new_o[8]); end
        end else if (pulses == 2) begin
          second_k = k;
          start = 1'b0;
          n_cmp++; if (delta !== 32'hFFFF_FFFD || b_new !== 32'h2 || e_o[4] !== 32'hFFFF_FFFF || w_new_o[0] !== 32'h0040_0002) begin
            n_err++; $display("FAIL b2b_op2: delta=%h b_new=%h e5=%h w_new1=%h required fffffffd/2/ffffffff/00400002",
                              delta, b_new, e_o[4], w_new_o[0]); end
        end
      end
      prev_done = done;
    end
    n_cmp++; if (pulses !== 2) begin
      n_err++; $display("FAIL b2b_pulses: got %0d required 2", pulses); end
    n_cmp++; if (second_k - first_k !== 22) begin
      n_err++; $display("FAIL b2b_spacing: got %0d required 22", second_k - first_k); end
  endtask

  // UPD(6) is the state after edge 14 from accept.
  task automatic test_reset_mid();
    int cyc;
    int late_done = 0;
    set_vec(ONE, 32'h0, 32'h0080_0000, 32'h0, ONE, 32'h0040_0000, 32'h0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k < 14; k++) @(negedge clk);
    rst = 1'b0; start = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || delta !== 32'h0 || b_new !== 32'h0) begin
      n_err++; $display("FAIL rstmid_immediate: busy=%b done=%b delta=%h b_new=%h required all 0", busy, done, delta, b_new); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (e_o[i] !== 32'h0 || w_new_o[i] !== 32'h0) begin
        n_err++; $display("FAIL rstmid_lane%0d: e=%h w_new=%h required 0/0", i + 1, e_o[i], w_new_o[i]); end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_start_ignored: busy=%b required 0", busy); end
    start = 1'b0; rst = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) late_done++;
    end
    n_cmp++; if (late_done !== 0) begin
      n_err++; $display("FAIL rstmid_no_done: %0d done cycles required 0", late_done); end
    run_op(0, cyc);
    n_cmp++; if (cyc !== 21 || delta !== ONE || w_new_o[5] !== 32'hFFC0_0000) begin
      n_err++; $display("FAIL rstmid_fresh: cyc=%0d delta=%h w_new6=%h required 21/01000000/ffc00000", cyc, delta, w_new_o[5]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_derivative();
    test_saturated();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
